// File: rtl/kinase_ctrl_pkg.sv
// Shared definitions for the kinase valve sequencer: opcodes, FSM state
// encoding, pad widths and peristaltic pump phase tables.
package kinase_ctrl_pkg;

  localparam int unsigned CTRL_A_W      = 13;
  localparam int unsigned CTRL_S_W      = 4;
  localparam int unsigned PUMP_A_W      = 3;
  localparam int unsigned PUMP_B_W      = 2;
  localparam int unsigned PUMP_A_PHASES = 6;
  localparam int unsigned PUMP_B_PHASES = 4;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_SET_A  = 3'd1;
  localparam logic [2:0] OP_SET_S  = 3'd2;
  localparam logic [2:0] OP_PUMP_A = 3'd3;
  localparam logic [2:0] OP_PUMP_B = 3'd4;
  localparam logic [2:0] OP_WAIT   = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_PUMP   = 2'd2,
    ST_WAIT   = 2'd3
  } state_t;

  // One pump stroke, entry 0 first.
  localparam logic [PUMP_A_W-1:0] PUMP_A_PATTERN [PUMP_A_PHASES] =
    '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
  localparam logic [PUMP_B_W-1:0] PUMP_B_PATTERN [PUMP_B_PHASES] =
    '{2'b01, 2'b11, 2'b10, 2'b00};

endpackage

// File: rtl/kinase_phase_timer.sv
// Reloadable down-counter: tick_c is high on the last cycle of every
// PHASE_CYCLES-cycle window while en is set.
// Ports: clk, rst_n, reload (restart window), en (count), tick_c (phase end).
module kinase_phase_timer #(
  parameter int unsigned PHASE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic reload,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CNT_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD_VAL = CNT_W'(PHASE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick_c = en && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (reload) begin
      cnt_q <= RELOAD_VAL;
    end else if (en) begin
      cnt_q <= (cnt_q == '0) ? RELOAD_VAL : cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/kinase_valve_sequencer.sv
// Kinase chip valve/pump sequencer. Accepts valid/ready commands, latches
// valve banks, runs peristaltic pump strokes and inserts settle/wait delays.
// Ports: clk, rst_n, cmd_valid/cmd_ready/cmd_op/cmd_arg (command stream),
//        abort, busy, done, err, pad_ctrl_a, pad_ctrl_s, pad_pump_a, pad_pump_b.
// Optional: define KINASE_STROKE_COUNT_EN to add stroke_count (saturating
//           count of completed pump strokes, cleared only by reset).
module kinase_valve_sequencer
  import kinase_ctrl_pkg::*;
#(
  parameter int unsigned PHASE_CYCLES  = 4,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned ARG_W         = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_op,
  input  logic [ARG_W-1:0]    cmd_arg,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [CTRL_A_W-1:0] pad_ctrl_a,
  output logic [CTRL_S_W-1:0] pad_ctrl_s,
  output logic [PUMP_A_W-1:0] pad_pump_a,
  output logic [PUMP_B_W-1:0] pad_pump_b
`ifdef KINASE_STROKE_COUNT_EN
  ,
  output logic [ARG_W-1:0]    stroke_count
`endif
);

  state_t             state_q, state_d;
  logic [ARG_W-1:0]   cnt_q, cnt_d;
  logic [ARG_W-1:0]   strokes_q, strokes_d;
  logic [2:0]         phase_q, phase_d;
  logic [2:0]         phase_inc_c;
  logic               sel_b_q, sel_b_d;
  logic [CTRL_A_W-1:0] ctrl_a_d;
  logic [CTRL_S_W-1:0] ctrl_s_d;
  logic [PUMP_A_W-1:0] pump_a_d;
  logic [PUMP_B_W-1:0] pump_b_d;
  logic               done_d, err_d;
  logic               timer_reload_c, tick_c, stroke_inc_c, last_phase_c;

  assign phase_inc_c  = phase_q + 3'd1;
  assign last_phase_c = sel_b_q ? (phase_q == 3'(PUMP_B_PHASES - 1))
                                : (phase_q == 3'(PUMP_A_PHASES - 1));

  kinase_phase_timer #(.PHASE_CYCLES(PHASE_CYCLES)) u_phase_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .reload (timer_reload_c),
    .en     (state_q == ST_PUMP),
    .tick_c (tick_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    strokes_d      = strokes_q;
    phase_d        = phase_q;
    sel_b_d        = sel_b_q;
    ctrl_a_d       = pad_ctrl_a;
    ctrl_s_d       = pad_ctrl_s;
    pump_a_d       = pad_pump_a;
    pump_b_d       = pad_pump_b;
    done_d         = 1'b0;
    err_d          = 1'b0;
    timer_reload_c = 1'b0;
    stroke_inc_c   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          unique case (cmd_op)
            OP_NOP: done_d = 1'b1;
            OP_SET_A: begin
              ctrl_a_d = cmd_arg[CTRL_A_W-1:0];
              cnt_d    = ARG_W'(SETTLE_CYCLES - 1);
              state_d  = ST_SETTLE;
            end
            OP_SET_S: begin
              ctrl_s_d = cmd_arg[CTRL_S_W-1:0];
              cnt_d    = ARG_W'(SETTLE_CYCLES - 1);
              state_d  = ST_SETTLE;
            end
            OP_PUMP_A, OP_PUMP_B: begin
              if (cmd_arg == '0) begin
                done_d = 1'b1;
              end else begin
                strokes_d      = cmd_arg;
                phase_d        = 3'd0;
                sel_b_d        = (cmd_op == OP_PUMP_B);
                timer_reload_c = 1'b1;
                state_d        = ST_PUMP;
                if (cmd_op == OP_PUMP_B) pump_b_d = PUMP_B_PATTERN[0];
                else                     pump_a_d = PUMP_A_PATTERN[0];
              end
            end
            OP_WAIT: begin
              if (cmd_arg == '0) begin
                done_d = 1'b1;
              end else begin
                cnt_d   = cmd_arg - ARG_W'(1);
                state_d = ST_WAIT;
              end
            end
            default: err_d = 1'b1;
          endcase
        end
      end

      ST_SETTLE, ST_WAIT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - ARG_W'(1);
        end
      end

      ST_PUMP: begin
        // abort wins over a coinciding phase tick, so the stroke is not counted
        if (abort) begin
          state_d  = ST_IDLE;
          pump_a_d = '0;
          pump_b_d = '0;
        end else if (tick_c) begin
          if (last_phase_c) begin
            stroke_inc_c = 1'b1;
            if (strokes_q == ARG_W'(1)) begin
              state_d  = ST_IDLE;
              done_d   = 1'b1;
              pump_a_d = '0;
              pump_b_d = '0;
            end else begin
              strokes_d = strokes_q - ARG_W'(1);
              phase_d   = 3'd0;
              if (sel_b_q) pump_b_d = PUMP_B_PATTERN[0];
              else         pump_a_d = PUMP_A_PATTERN[0];
            end
          end else begin
            phase_d = phase_inc_c;
            if (sel_b_q) pump_b_d = PUMP_B_PATTERN[phase_inc_c[1:0]];
            else         pump_a_d = PUMP_A_PATTERN[phase_inc_c];
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      strokes_q  <= '0;
      phase_q    <= '0;
      sel_b_q    <= 1'b0;
      pad_ctrl_a <= '0;
      pad_ctrl_s <= '0;
      pad_pump_a <= '0;
      pad_pump_b <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      cmd_ready  <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      strokes_q  <= strokes_d;
      phase_q    <= phase_d;
      sel_b_q    <= sel_b_d;
      pad_ctrl_a <= ctrl_a_d;
      pad_ctrl_s <= ctrl_s_d;
      pad_pump_a <= pump_a_d;
      pad_pump_b <= pump_b_d;
      done       <= done_d;
      err        <= err_d;
      busy       <= (state_d != ST_IDLE);
      cmd_ready  <= (state_d == ST_IDLE);
    end
  end

`ifdef KINASE_STROKE_COUNT_EN
  // Saturating completed-stroke counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stroke_count <= '0;
    end else if (stroke_inc_c && (stroke_count != '1)) begin
      stroke_count <= stroke_count + ARG_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_kinase_valve_sequencer.sv
// Self-checking bench for kinase_valve_sequencer: directed scenarios plus
// randomized command streams checked against a cycle-index reference model.
module tb_kinase_valve_sequencer;

  localparam int P     = 4;
  localparam int SC    = 8;
  localparam int ARG_W = 16;

  localparam logic [2:0] NOP = 3'd0, SETA = 3'd1, SETS = 3'd2,
                         PMPA = 3'd3, PMPB = 3'd4, WAITC = 3'd5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic [2:0] cmd_op = '0;
  logic [ARG_W-1:0] cmd_arg = '0;
  logic abort = 1'b0;
  logic cmd_ready, busy, done, err;
  logic [12:0] pad_ctrl_a;
  logic [3:0]  pad_ctrl_s;
  logic [2:0]  pad_pump_a;
  logic [1:0]  pad_pump_b;
`ifdef KINASE_STROKE_COUNT_EN
  logic [ARG_W-1:0] stroke_count;
`endif

  kinase_valve_sequencer #(.PHASE_CYCLES(P), .SETTLE_CYCLES(SC), .ARG_W(ARG_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .abort(abort), .busy(busy), .done(done),
    .err(err), .pad_ctrl_a(pad_ctrl_a), .pad_ctrl_s(pad_ctrl_s),
    .pad_pump_a(pad_pump_a), .pad_pump_b(pad_pump_b)
`ifdef KINASE_STROKE_COUNT_EN
    , .stroke_count(stroke_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [12:0] exp_a = '0;
  logic [3:0]  exp_s = '0;
  int          exp_cnt = 0;
  logic [2:0]  pa_tab [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
  logic [1:0]  pb_tab [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

  function automatic logic [25:0] obs();
    return {busy, cmd_ready, done, err, pad_ctrl_a, pad_ctrl_s, pad_pump_a, pad_pump_b};
  endfunction

  // Issue one command from IDLE (called at a negedge) and check every cycle
  // until one cycle after it retires. ab>=1 aborts during cycle T+ab.
  task automatic do_cmd(input logic [2:0] op, input logic [ARG_W-1:0] arg, input int ab_in);
    int len, nph, lim, ab, strokes_done;
    logic [2:0] epa;
    logic [1:0] epb;
    logic [25:0] expv;
    ab = ab_in;
    nph = (op == PMPA) ? 6 : 4;
    case (op)
      SETA, SETS:  len = SC;
      PMPA, PMPB:  len = int'(arg) * nph * P;
      WAITC:       len = int'(arg);
      default:     len = 0;
    endcase
    if (len == 0) ab = -1;
    if (ab > len) ab = len;
    if ((op == PMPA || op == PMPB) && ab > 0 && (ab % (nph * P)) == 0) ab = ab - 1;

    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_before_op%0d got=%b exp=1", op, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg; abort = (ab == 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_arg   = ARG_W'($urandom);

    lim = (ab >= 1) ? ab + 1 : len + 1;
    for (int k = 1; k < lim; k++) begin
      abort = (k == ab);
      if (op == SETA) exp_a = arg[12:0];
      if (op == SETS) exp_s = arg[3:0];
      epa = (op == PMPA) ? pa_tab[((k - 1) / P) % 6] : 3'b000;
      epb = (op == PMPB) ? pb_tab[((k - 1) / P) % 4] : 2'b00;
      expv = {1'b1, 1'b0, 1'b0, 1'b0, exp_a, exp_s, epa, epb};
      total++;
      if (obs() !== expv) begin
        bad++;
        $display("FAIL op%0d_arg%0d_cyc%0d got=%h exp=%h", op, arg, k, obs(), expv);
      end
      @(negedge clk);
    end
    abort = 1'b0;

    if (op == PMPA || op == PMPB) begin
      strokes_done = (ab >= 1) ? ab / (nph * P) : int'(arg);
      exp_cnt = exp_cnt + strokes_done;
      if (exp_cnt > 65535) exp_cnt = 65535;
    end
    expv = {1'b0, 1'b1, (ab < 1) && (op <= WAITC), (op > WAITC), exp_a, exp_s, 3'b000, 2'b00};
    total++;
    if (obs() !== expv) begin
      bad++;
      $display("FAIL op%0d_arg%0d_retire got=%h exp=%h", op, arg, obs(), expv);
    end
`ifdef KINASE_STROKE_COUNT_EN
    total++;
    if (stroke_count !== ARG_W'(exp_cnt)) begin
      bad++;
      $display("FAIL stroke_count_op%0d got=%0d exp=%0d", op, stroke_count, exp_cnt);
    end
`endif
    @(negedge clk);
    expv = {1'b0, 1'b1, 1'b0, 1'b0, exp_a, exp_s, 3'b000, 2'b00};
    total++;
    if (obs() !== expv) begin
      bad++;
      $display("FAIL op%0d_after_pulse got=%h exp=%h", op, obs(), expv);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if (obs() !== {1'b0, 1'b1, 1'b0, 1'b0, 13'h0, 4'h0, 3'h0, 2'h0}) begin
      bad++;
      $display("FAIL reset_values got=%h exp=%h", obs(), {4'b0100, 22'h0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_set_valves();
    do_cmd(SETA, 16'h1ABC, -1);
    do_cmd(SETS, 16'h0005, -1);
  endtask

  task automatic test_pump_a();
    do_cmd(PMPA, 16'd2, -1);
  endtask

  task automatic test_zero_operand();
    do_cmd(PMPB, 16'd0, -1);
    do_cmd(WAITC, 16'd0, -1);
    do_cmd(PMPA, 16'd0, -1);
  endtask

  task automatic test_abort();
    do_cmd(PMPB, 16'd5, 10);
    do_cmd(SETS, 16'h000A, 1);   // abort alongside accept, held one more cycle
    do_cmd(WAITC, 16'd9, 4);
    // abort while idle must be ignored
    for (int k = 0; k < 3; k++) begin
      abort = 1'b1;
      @(negedge clk);
      total++;
      if (obs() !== {1'b0, 1'b1, 1'b0, 1'b0, exp_a, exp_s, 3'b000, 2'b00}) begin
        bad++;
        $display("FAIL abort_idle_%0d got=%h", k, obs());
      end
    end
    abort = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_illegal();
    do_cmd(3'd7, 16'hFFFF, -1);
    do_cmd(3'd6, 16'h1234, -1);
  endtask

  task automatic test_back_to_back();
    cmd_valid = 1'b1; cmd_op = WAITC; cmd_arg = 16'd20;
    @(negedge clk);
    cmd_op = NOP;                 // held valid while the WAIT is busy
    for (int k = 1; k <= 20; k++) begin
      total++;
      if ({busy, cmd_ready, done, err} !== 4'b1000) begin
        bad++;
        $display("FAIL b2b_busy_cyc%0d got=%b exp=1000", k, {busy, cmd_ready, done, err});
      end
      @(negedge clk);
    end
    total++;
    if ({busy, cmd_ready, done, err} !== 4'b0110) begin
      bad++;
      $display("FAIL b2b_wait_done got=%b exp=0110", {busy, cmd_ready, done, err});
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    total++;
    if ({busy, cmd_ready, done, err} !== 4'b0110) begin
      bad++;
      $display("FAIL b2b_nop_done got=%b exp=0110", {busy, cmd_ready, done, err});
    end
    @(negedge clk);
    total++;
    if (obs() !== {1'b0, 1'b1, 1'b0, 1'b0, exp_a, exp_s, 3'b000, 2'b00}) begin
      bad++;
      $display("FAIL b2b_quiet got=%h", obs());
    end
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [ARG_W-1:0] arg;
    int ab;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      case (op)
        PMPA, PMPB: arg = ARG_W'($urandom_range(0, 3));
        WAITC:      arg = ARG_W'($urandom_range(0, 25));
        default:    arg = ARG_W'($urandom);
      endcase
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 80)) : -1;
      do_cmd(op, arg, ab);
    end
  endtask

  task automatic test_async_reset();
    cmd_valid = 1'b1; cmd_op = PMPA; cmd_arg = 16'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (7) @(negedge clk);
    total++;
    if (pad_pump_a !== 3'b011) begin
      bad++;
      $display("FAIL async_pre_pump got=%b exp=011", pad_pump_a);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (obs() !== {1'b0, 1'b1, 1'b0, 1'b0, 13'h0, 4'h0, 3'h0, 2'h0}) begin
      bad++;
      $display("FAIL async_reset got=%h exp=%h", obs(), {4'b0100, 22'h0});
    end
    exp_a = '0; exp_s = '0; exp_cnt = 0;
`ifdef KINASE_STROKE_COUNT_EN
    total++;
    if (stroke_count !== '0) begin
      bad++;
      $display("FAIL async_reset_count got=%0d exp=0", stroke_count);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_cmd(PMPB, 16'd1, -1);
  endtask

  initial begin
    test_reset();
    test_set_valves();
    test_pump_a();
    test_zero_operand();
    test_abort();
    test_illegal();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
